// File: rtl/divisor_param.sv
// divisor_param: sequential unsigned divider (restoring, one quotient bit per clock).
// IDLE -> BUSY -> DONE handshake on inicie/termino. A zero divisor finishes after a
// single BUSY cycle with a saturated quotient and div_cero set.
// Build option: define DIV_RESIDUO_EN to add the residuo output port and register.
module divisor_param #(
    parameter int unsigned DD_W = 16,
    parameter int unsigned DV_W = 8
) (
    input  logic            clk,
    input  logic            reset_L,
    input  logic            inicie,
    input  logic [DD_W-1:0] dividendo,
    input  logic [DV_W-1:0] divisor,
    output logic            termino,
    output logic [DD_W-1:0] cociente,
`ifdef DIV_RESIDUO_EN
    output logic [DV_W-1:0] residuo,
`endif
    output logic            div_cero
);

    localparam int unsigned CW = (DD_W > 1) ? $clog2(DD_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;

    logic [DD_W-1:0] q;        // dividend shifting out, quotient shifting in
    logic [DV_W-1:0] rem;      // partial remainder (always < divisor)
    logic [DV_W-1:0] dv;       // latched divisor
    logic [CW-1:0]   count;    // quotient bits produced so far

    logic [DV_W:0]   shifted;
    logic            fits;
    logic [DV_W-1:0] rem_next;
    logic [DD_W-1:0] q_next;
    logic            last;
    logic            dv_zero;

    // One restoring step: shift in next dividend bit, subtract divisor if it fits.
    always_comb begin
        shifted  = {rem, q[DD_W-1]};
        fits     = (shifted >= {1'b0, dv});
        rem_next = DV_W'(fits ? (shifted - {1'b0, dv}) : shifted);
        q_next   = {q[DD_W-2:0], fits};
        last     = (count == CW'(DD_W - 1));
        dv_zero  = (dv == '0);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_L) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state logic and the ready/done flag.
    always_comb begin
        state_next = state;
        termino    = 1'b1;
        case (state)
            IDLE: if (inicie) state_next = BUSY;
            BUSY: begin
                termino = 1'b0;
                if (dv_zero || last) state_next = DONE;
            end
            DONE: if (!inicie) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands on start, iterate in BUSY, publish results on DONE entry.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            q        <= '0;
            rem      <= '0;
            dv       <= '0;
            count    <= '0;
            cociente <= '0;
`ifdef DIV_RESIDUO_EN
            residuo  <= '0;
`endif
            div_cero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inicie) begin
                        q     <= dividendo;
                        dv    <= divisor;
                        rem   <= '0;
                        count <= '0;
                    end
                end
                BUSY: begin
                    if (dv_zero) begin
                        cociente <= '1;
`ifdef DIV_RESIDUO_EN
                        residuo  <= '0;
`endif
                        div_cero <= 1'b1;
                    end else begin
                        q     <= q_next;
                        rem   <= rem_next;
                        count <= count + 1'b1;
                        if (last) begin
                            cociente <= q_next;
`ifdef DIV_RESIDUO_EN
                            residuo  <= rem_next;
`endif
                            div_cero <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_param.sv
// Self-checking bench for divisor_param (DD_W=16, DV_W=8).
// Remainder checks are compiled in only when DIV_RESIDUO_EN is defined.
module tb_divisor_param;

    logic        clk;
    logic        reset_L;
    logic        inicie;
    logic [15:0] dividendo;
    logic [7:0]  divisor;
    logic        termino;
    logic [15:0] cociente;
`ifdef DIV_RESIDUO_EN
    logic [7:0]  residuo;
`endif
    logic        div_cero;

    int unsigned total;
    int unsigned passed;

    divisor_param #(.DD_W(16), .DV_W(8)) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .inicie    (inicie),
        .dividendo (dividendo),
        .divisor   (divisor),
        .termino   (termino),
        .cociente  (cociente),
`ifdef DIV_RESIDUO_EN
        .residuo   (residuo),
`endif
        .div_cero  (div_cero)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Start a division and wait (bounded) for termino; inicie stays high on return.
    // Operands are scrambled right after the start edge to prove they are ignored.
    task automatic do_div(input logic [15:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        dividendo = a;
        divisor   = b;
        inicie    = 1'b1;
        @(posedge clk); #1;
        dividendo = ~a;
        divisor   = ~b;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (termino !== 1'b1 && lat < 100);
    endtask

    // Drop inicie so DONE returns to IDLE.
    task automatic release_ack();
        @(negedge clk);
        inicie = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset_L   = 1'b0;
        inicie    = 1'b0;
        dividendo = 16'h0000;
        divisor   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        total++; if (termino !== 1'b1) $display("FAIL reset_termino got=%b exp=1", termino); else passed++;
        total++; if (cociente !== 16'h0000) $display("FAIL reset_cociente got=%h exp=0000", cociente); else passed++;
        total++; if (div_cero !== 1'b0) $display("FAIL reset_div_cero got=%b exp=0", div_cero); else passed++;
`ifdef DIV_RESIDUO_EN
        total++; if (residuo !== 8'h00) $display("FAIL reset_residuo got=%h exp=00", residuo); else passed++;
`endif
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        do_div(16'h03E8, 8'h07, lat);
        total++; if (lat != 16) $display("FAIL basic_latency got=%0d exp=16", lat); else passed++;
        total++; if (cociente !== 16'h008E) $display("FAIL basic_cociente got=%h exp=008e", cociente); else passed++;
        total++; if (div_cero !== 1'b0) $display("FAIL basic_div_cero got=%b exp=0", div_cero); else passed++;
`ifdef DIV_RESIDUO_EN
        total++; if (residuo !== 8'h06) $display("FAIL basic_residuo got=%h exp=06", residuo); else passed++;
`endif
        release_ack();
        total++; if (cociente !== 16'h008E) $display("FAIL idle_hold_cociente got=%h exp=008e", cociente); else passed++;
    endtask

    task automatic test_extremes();
        int lat;
        do_div(16'hFFFF, 8'h01, lat);
        total++; if (lat != 16) $display("FAIL ext1_latency got=%0d exp=16", lat); else passed++;
        total++; if (cociente !== 16'hFFFF) $display("FAIL ext1_cociente got=%h exp=ffff", cociente); else passed++;
`ifdef DIV_RESIDUO_EN
        total++; if (residuo !== 8'h00) $display("FAIL ext1_residuo got=%h exp=00", residuo); else passed++;
`endif
        release_ack();
        do_div(16'h0005, 8'h09, lat);
        total++; if (cociente !== 16'h0000) $display("FAIL ext2_cociente got=%h exp=0000", cociente); else passed++;
`ifdef DIV_RESIDUO_EN
        total++; if (residuo !== 8'h05) $display("FAIL ext2_residuo got=%h exp=05", residuo); else passed++;
`endif
        release_ack();
        do_div(16'hFFFF, 8'hFF, lat);
        total++; if (cociente !== 16'h0101) $display("FAIL ext3_cociente got=%h exp=0101", cociente); else passed++;
`ifdef DIV_RESIDUO_EN
        total++; if (residuo !== 8'h00) $display("FAIL ext3_residuo got=%h exp=00", residuo); else passed++;
`endif
        release_ack();
    endtask

    task automatic test_div_zero();
        int lat;
        do_div(16'h1234, 8'h00, lat);
        total++; if (lat != 1) $display("FAIL dz_latency got=%0d exp=1", lat); else passed++;
        total++; if (cociente !== 16'hFFFF) $display("FAIL dz_cociente got=%h exp=ffff", cociente); else passed++;
        total++; if (div_cero !== 1'b1) $display("FAIL dz_div_cero got=%b exp=1", div_cero); else passed++;
`ifdef DIV_RESIDUO_EN
        total++; if (residuo !== 8'h00) $display("FAIL dz_residuo got=%h exp=00", residuo); else passed++;
`endif
        release_ack();
        do_div(16'h0010, 8'h04, lat);
        total++; if (lat != 16) $display("FAIL dz_next_latency got=%0d exp=16", lat); else passed++;
        total++; if (cociente !== 16'h0004) $display("FAIL dz_next_cociente got=%h exp=0004", cociente); else passed++;
        total++; if (div_cero !== 1'b0) $display("FAIL dz_next_div_cero got=%b exp=0", div_cero); else passed++;
        release_ack();
    endtask

    task automatic test_handshake();
        int lat;
        int term_drops;
        int q_changes;
        do_div(16'h03E8, 8'h07, lat);
        term_drops = 0;
        q_changes  = 0;
        // inicie stays high; operands were scrambled, so a restart would be visible.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (termino !== 1'b1) term_drops++;
            if (cociente !== 16'h008E) q_changes++;
        end
        total++; if (term_drops != 0) $display("FAIL hs_hold_termino low_cycles=%0d exp=0", term_drops); else passed++;
        total++; if (q_changes != 0) $display("FAIL hs_hold_cociente changed_cycles=%0d exp=0", q_changes); else passed++;
        release_ack();
        total++; if (termino !== 1'b1) $display("FAIL hs_idle_termino got=%b exp=1", termino); else passed++;
        do_div(16'hABCD, 8'hFF, lat);
        total++; if (lat != 16) $display("FAIL hs_restart_latency got=%0d exp=16", lat); else passed++;
        total++; if (cociente !== 16'h00AC) $display("FAIL hs_restart_cociente got=%h exp=00ac", cociente); else passed++;
`ifdef DIV_RESIDUO_EN
        total++; if (residuo !== 8'h79) $display("FAIL hs_restart_residuo got=%h exp=79", residuo); else passed++;
`endif
        release_ack();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        // Leave a nonzero quotient (0x0004) in place so the reset clear is observable.
        do_div(16'h0010, 8'h04, lat);
        release_ack();
        @(negedge clk);
        dividendo = 16'h1234;
        divisor   = 8'h03;
        inicie    = 1'b1;
        @(posedge clk); #1;             // BUSY cycle 1
        inicie = 1'b0;
        total++; if (termino !== 1'b0) $display("FAIL mid_busy_termino got=%b exp=0", termino); else passed++;
        repeat (4) @(posedge clk);      // now in BUSY cycle 5
        @(negedge clk);
        reset_L = 1'b0;
        @(posedge clk); #1;
        total++; if (termino !== 1'b1) $display("FAIL mid_reset_termino got=%b exp=1", termino); else passed++;
        total++; if (cociente !== 16'h0000) $display("FAIL mid_reset_cociente got=%h exp=0000", cociente); else passed++;
        @(negedge clk);
        reset_L = 1'b1;
        do_div(16'h0064, 8'h0A, lat);
        total++; if (lat != 16) $display("FAIL post_reset_latency got=%0d exp=16", lat); else passed++;
        total++; if (cociente !== 16'h000A) $display("FAIL post_reset_cociente got=%h exp=000a", cociente); else passed++;
`ifdef DIV_RESIDUO_EN
        total++; if (residuo !== 8'h00) $display("FAIL post_reset_residuo got=%h exp=00", residuo); else passed++;
`endif
        release_ack();
    endtask

    // Scenario sequence.
    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_handshake();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/divisor_param.md
DIVISOR_PARAM -- requirements
Module: divisor_param

Interface
REQ-001 SHALL have parameter DD_W, default 16, dividend and quotient width in bits (legal range 2..32).
REQ-002 SHALL have parameter DV_W, default 8, divisor and remainder width in bits (legal range 2..DD_W).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_L  input  1  synchronous, active-low reset.
REQ-005 inicie  input  1  start/acknowledge request from the driving side.
REQ-006 dividendo  input  DD_W  unsigned dividend.
REQ-007 divisor  input  DV_W  unsigned divisor.
REQ-008 termino  output  1  high while ready (IDLE) or result valid (DONE); low while busy.
REQ-009 cociente  output  DD_W  unsigned quotient.
REQ-010 residuo  output  DV_W  unsigned remainder (present only per REQ-027).
REQ-011 div_cero  output  1  high with a result when the latched divisor was zero.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: termino=1; inicie=1 sampled on an edge SHALL latch dividendo/divisor and move to BUSY.
REQ-014 BUSY: termino=0; operand input changes SHALL be ignored.
REQ-015 SHALL use restoring division, one quotient bit per cycle, MSB first, with a DV_W+1-bit partial remainder.
REQ-016 Nonzero divisor: BUSY SHALL last exactly DD_W cycles; termino rises on the DD_W-th edge after the start edge.
REQ-017 Zero divisor: BUSY SHALL last exactly 1 cycle; the result is cociente=all ones, residuo=0, div_cero=1.
REQ-018 On entry to DONE, cociente/residuo/div_cero SHALL update in the same edge that raises termino.
REQ-019 DONE: termino=1; outputs held; SHALL stay until inicie=0 is sampled, then go to IDLE.
REQ-020 inicie held high through DONE SHALL NOT start a new division; a new start requires inicie low, then high, in IDLE.
REQ-021 In IDLE, outputs SHALL retain the last result until the next DONE entry.
REQ-022 A nonzero division SHALL give cociente*divisor+residuo == dividendo with residuo < divisor.
REQ-023 div_cero SHALL be cleared on any DONE entry with a nonzero divisor.

Reset
REQ-024 reset_L=0 sampled on an edge SHALL force IDLE, termino=1, cociente=0, residuo=0, div_cero=0, in any state.
REQ-025 Reset during BUSY SHALL abandon the operation with no partial result visible.
REQ-026 After reset release, the first edge with inicie=1 in IDLE SHALL start a division.

Configuration
REQ-027 Macro DIV_RESIDUO_EN defined: the residuo port and its output register SHALL exist and behave per REQ-015..022.
REQ-028 Macro DIV_RESIDUO_EN undefined: the residuo port SHALL be absent; quotient behaviour and latency SHALL be unchanged.

Verification (DD_W=16, DV_W=8, DIV_RESIDUO_EN defined unless stated)
REQ-029 Basic: 0x03E8/0x07 -> cociente=0x008E, residuo=0x06, div_cero=0; termino low exactly 16 cycles.
REQ-030 Extremes: 0xFFFF/0x01 -> 0xFFFF r 0x00; 0x0005/0x09 -> 0x0000 r 0x05.
REQ-031 Div by zero: 0x1234/0x00 -> cociente=0xFFFF, residuo=0x00, div_cero=1, termino low 1 cycle; next 0x0010/0x04 -> 0x0004, div_cero=0.
REQ-032 Handshake: inicie held high 20 cycles after termino rises -> no second division; drop then raise -> new division starts.
REQ-033 Reset mid-op: reset_L=0 at 5th BUSY cycle -> next edge termino=1, cociente=0; then 0x0064/0x0A -> 0x000A r 0x00.
REQ-034 Build without DIV_RESIDUO_EN: REQ-029 stimulus -> cociente=0x008E, latency 16; no residuo port present.
